// File: rtl/softmax_seq_ctrl.sv
// Sequencer for the I_SOFTMAX datapath: MAX and ACC streaming passes over the row
// buffer, then a NORM pass presenting each element over a valid/ready handshake.
module softmax_seq_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DP_LAT = 3
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sm_clr,
  output logic              EN_max,
  output logic              EN_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CLR  = 4'd1;
  localparam logic [3:0] S_MAX  = 4'd2;
  localparam logic [3:0] S_DRN1 = 4'd3;
  localparam logic [3:0] S_ACC  = 4'd4;
  localparam logic [3:0] S_DRN2 = 4'd5;
  localparam logic [3:0] S_NRD  = 4'd6;
  localparam logic [3:0] S_NWT  = 4'd7;
  localparam logic [3:0] S_NOUT = 4'd8;
  localparam logic [3:0] S_DONE = 4'd9;

  localparam int              WW      = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [WW-1:0]   W_LAST  = WW'(DP_LAT - 1);
  localparam logic [WW-1:0]   W_ONE   = WW'(1);
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]      rst_sync;
  logic            rst_n_i;
  logic [3:0]      state_q,   state_d;
  logic [ADDR_W:0] idx_q,     idx_d;
  logic [ADDR_W:0] last_q,    last_d;
  logic [WW-1:0]   wcnt_q,    wcnt_d;
  logic            len_err_q, len_err_d;
  logic            en_max_q,  en_max_d;
  logic            en_acc_q,  en_acc_d;
  logic            len_ok;

  // Reset asserts immediately but releases two clocks after RST_n rises.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign len_ok = (len != '0) && (len <= LEN_MAX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wcnt_d    = '0;
    len_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            last_d  = len - IDX_ONE;
            state_d = S_CLR;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        idx_d   = '0;
        state_d = S_MAX;
      end
      S_MAX, S_ACC: begin
        idx_d = idx_q + IDX_ONE;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = (state_q == S_MAX) ? S_DRN1 : S_DRN2;
        end
      end
      S_DRN1, S_DRN2, S_NWT: begin
        if (state_q != S_NWT) idx_d = '0;
        wcnt_d = wcnt_q + W_ONE;
        if (wcnt_q == W_LAST) begin
          wcnt_d = '0;
          case (state_q)
            S_DRN1:  state_d = S_ACC;
            S_DRN2:  state_d = S_NRD;
            default: state_d = S_NOUT;
          endcase
        end
      end
      S_NRD: state_d = S_NWT;
      S_NOUT: begin
        if (out_ready) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_NRD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a start seen in the same IDLE cycle.
    if (abort) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      wcnt_d    = '0;
      len_err_d = 1'b0;
    end
    en_max_d = (state_q == S_MAX) && !abort;
    en_acc_d = (state_q == S_ACC) && !abort;
  end

  always_ff @(posedge CLK or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      wcnt_q    <= '0;
      len_err_q <= 1'b0;
      en_max_q  <= 1'b0;
      en_acc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      len_err_q <= len_err_d;
      en_max_q  <= en_max_d;
      en_acc_q  <= en_acc_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign len_err   = len_err_q;
  assign rd_en     = (state_q == S_MAX) || (state_q == S_ACC) || (state_q == S_NRD);
  assign rd_addr   = rd_en ? idx_q[ADDR_W-1:0] : '0;
  assign sm_clr    = (state_q == S_CLR);
  assign EN_max    = en_max_q;
  assign EN_acc    = en_acc_q;
  assign out_valid = (state_q == S_NOUT);
  assign out_idx   = out_valid ? idx_q[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl: cycle-exact pass timing, length limits,
// output stall, abort and asynchronous reset recovery.
module tb_softmax_seq_ctrl;
  localparam int ADDR_W = 6;
  localparam int DP_LAT = 3;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic              busy, done, len_err, rd_en, sm_clr, EN_max, EN_acc, out_valid;
  logic [ADDR_W-1:0] rd_addr, out_idx;

  softmax_seq_ctrl #(.ADDR_W(ADDR_W), .DP_LAT(DP_LAT)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .len_err(len_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .sm_clr(sm_clr), .EN_max(EN_max), .EN_acc(EN_acc), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event logs, sampled on the falling edge; cycle stamps are absolute.
  int   rd_a[$], rd_c[$], emax_c[$], eacc_c[$], hs_i[$], done_c[$], lerr_c[$], busy_r_c[$], clr_c[$];
  int   both_n = 0;
  logic busy_p = 1'b0;
  always @(negedge CLK) begin
    if (rd_en === 1'b1) begin rd_a.push_back(int'(rd_addr)); rd_c.push_back(cyc); end
    if (EN_max === 1'b1) emax_c.push_back(cyc);
    if (EN_acc === 1'b1) eacc_c.push_back(cyc);
    if (EN_max === 1'b1 && EN_acc === 1'b1) both_n++;
    if (out_valid === 1'b1 && out_ready === 1'b1) hs_i.push_back(int'(out_idx));
    if (done === 1'b1) done_c.push_back(cyc);
    if (len_err === 1'b1) lerr_c.push_back(cyc);
    if (sm_clr === 1'b1) clr_c.push_back(cyc);
    if (busy === 1'b1 && busy_p !== 1'b1) busy_r_c.push_back(cyc);
    busy_p = busy;
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_start(input int l);
    len   = l[ADDR_W:0];
    start = 1'b1;
    base  = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done === 1'b1) break;
    end
    step();
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, done, len_err, rd_en, rd_addr, sm_clr, EN_max, EN_acc, out_valid, out_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {busy, done, len_err, rd_en, rd_addr, sm_clr, EN_max, EN_acc, out_valid, out_idx});
    end
    @(posedge CLK); #1;
    RST_n = 1'b1;
    repeat (4) step();
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got busy=%b rd_en=%b exp 0 0", busy, rd_en);
    end
    step();
  endtask

  task automatic test_len4();
    int r0 = rd_a.size(), m0 = emax_c.size(), a0 = eacc_c.size(), h0 = hs_i.size();
    int d0 = done_c.size(), c0 = clr_c.size(), b0 = busy_r_c.size(), n0 = both_n;
    int exp_rc[12] = '{2, 3, 4, 5, 9, 10, 11, 12, 16, 21, 26, 31};
    int exp_em[4]  = '{3, 4, 5, 6};
    int exp_ea[4]  = '{10, 11, 12, 13};
    out_ready = 1'b1;
    do_start(4);
    wait_done(100);
    checks++;
    if (done_c.size() - d0 !== 1) begin errors++; $display("FAIL len4_done_count got %0d exp 1", done_c.size() - d0); end
    else begin
      checks++;
      if (done_c[d0] - base !== 36) begin errors++; $display("FAIL len4_done_cycle got %0d exp 36", done_c[d0] - base); end
    end
    checks++;
    if (rd_a.size() - r0 !== 12) begin errors++; $display("FAIL len4_rd_count got %0d exp 12", rd_a.size() - r0); end
    else for (int i = 0; i < 12; i++) begin
      checks++;
      if (rd_a[r0+i] !== i % 4 || rd_c[r0+i] - base !== exp_rc[i]) begin
        errors++;
        $display("FAIL len4_rd[%0d] got addr %0d cyc %0d exp addr %0d cyc %0d", i, rd_a[r0+i], rd_c[r0+i] - base, i % 4, exp_rc[i]);
      end
    end
    checks++;
    if (emax_c.size() - m0 !== 4 || eacc_c.size() - a0 !== 4) begin
      errors++; $display("FAIL len4_en_counts got max %0d acc %0d exp 4 4", emax_c.size() - m0, eacc_c.size() - a0);
    end else for (int i = 0; i < 4; i++) begin
      checks++;
      if (emax_c[m0+i] - base !== exp_em[i] || eacc_c[a0+i] - base !== exp_ea[i]) begin
        errors++;
        $display("FAIL len4_en[%0d] got max %0d acc %0d exp %0d %0d", i, emax_c[m0+i] - base, eacc_c[a0+i] - base, exp_em[i], exp_ea[i]);
      end
    end
    checks++;
    if (hs_i.size() - h0 !== 4) begin errors++; $display("FAIL len4_hs_count got %0d exp 4", hs_i.size() - h0); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_i[h0+i] !== i) begin errors++; $display("FAIL len4_hs_idx[%0d] got %0d exp %0d", i, hs_i[h0+i], i); end
    end
    checks++;
    if (clr_c.size() - c0 !== 1 || clr_c[clr_c.size()-1] - base !== 1) begin
      errors++; $display("FAIL len4_sm_clr got count %0d exp one pulse at cycle 1", clr_c.size() - c0);
    end
    checks++;
    if (busy_r_c.size() - b0 !== 1 || busy_r_c[busy_r_c.size()-1] - base !== 1) begin
      errors++; $display("FAIL len4_busy_rise got count %0d exp one rise at cycle 1", busy_r_c.size() - b0);
    end
    checks++;
    if (both_n - n0 !== 0) begin errors++; $display("FAIL len4_en_overlap got %0d exp 0", both_n - n0); end
  endtask

  task automatic test_len1();
    int r0 = rd_a.size(), m0 = emax_c.size(), a0 = eacc_c.size(), h0 = hs_i.size(), d0 = done_c.size();
    int exp_rc[3] = '{2, 6, 10};
    out_ready = 1'b1;
    do_start(1);
    wait_done(60);
    checks++;
    if (done_c.size() - d0 !== 1 || done_c[done_c.size()-1] - base !== 15) begin
      errors++; $display("FAIL len1_done got count %0d exp one pulse at cycle 15", done_c.size() - d0);
    end
    checks++;
    if (rd_a.size() - r0 !== 3) begin errors++; $display("FAIL len1_rd_count got %0d exp 3", rd_a.size() - r0); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_a[r0+i] !== 0 || rd_c[r0+i] - base !== exp_rc[i]) begin
        errors++; $display("FAIL len1_rd[%0d] got addr %0d cyc %0d exp addr 0 cyc %0d", i, rd_a[r0+i], rd_c[r0+i] - base, exp_rc[i]);
      end
    end
    checks++;
    if (emax_c.size() - m0 !== 1 || eacc_c.size() - a0 !== 1 ||
        emax_c[emax_c.size()-1] - base !== 3 || eacc_c[eacc_c.size()-1] - base !== 7) begin
      errors++; $display("FAIL len1_en got max count %0d acc count %0d exp 1 at cycle 3, 1 at cycle 7", emax_c.size() - m0, eacc_c.size() - a0);
    end
    checks++;
    if (hs_i.size() - h0 !== 1 || hs_i[hs_i.size()-1] !== 0) begin
      errors++; $display("FAIL len1_hs got count %0d exp 1 beat idx 0", hs_i.size() - h0);
    end
  endtask

  task automatic test_len64();
    int r0 = rd_a.size(), h0 = hs_i.size(), d0 = done_c.size(), bad = 0;
    out_ready = 1'b1;
    do_start(64);
    wait_done(600);
    checks++;
    if (done_c.size() - d0 !== 1 || done_c[done_c.size()-1] - base !== 456) begin
      errors++; $display("FAIL len64_done got count %0d exp one pulse at cycle 456", done_c.size() - d0);
    end
    checks++;
    if (rd_a.size() - r0 !== 192) begin errors++; $display("FAIL len64_rd_count got %0d exp 192", rd_a.size() - r0); end
    else begin
      for (int i = 0; i < 192; i++) if (rd_a[r0+i] !== i % 64) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL len64_rd_addr_seq got %0d bad addresses exp 0", bad); end
      checks++;
      if (rd_a[r0+63] !== 63 || rd_a[r0+64] !== 0) begin
        errors++; $display("FAIL len64_last_addr got %0d then %0d exp 63 then 0", rd_a[r0+63], rd_a[r0+64]);
      end
    end
    checks++;
    if (hs_i.size() - h0 !== 64) begin errors++; $display("FAIL len64_hs_count got %0d exp 64", hs_i.size() - h0); end
    else begin
      bad = 0;
      for (int i = 0; i < 64; i++) if (hs_i[h0+i] !== i) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL len64_hs_seq got %0d bad indices exp 0", bad); end
    end
  endtask

  task automatic test_len_err();
    int bad_len[2] = '{0, 65};
    foreach (bad_len[k]) begin
      int r0 = rd_a.size(), l0 = lerr_c.size(), b0 = busy_r_c.size();
      do_start(bad_len[k]);
      repeat (4) step();
      checks++;
      if (lerr_c.size() - l0 !== 1 || lerr_c[lerr_c.size()-1] - base !== 1) begin
        errors++; $display("FAIL len_err_pulse_len%0d got count %0d exp one pulse at cycle 1", bad_len[k], lerr_c.size() - l0);
      end
      checks++;
      if (busy_r_c.size() - b0 !== 0 || rd_a.size() - r0 !== 0) begin
        errors++; $display("FAIL len_err_quiet_len%0d got busy rises %0d reads %0d exp 0 0", bad_len[k], busy_r_c.size() - b0, rd_a.size() - r0);
      end
    end
    begin
      int l0 = lerr_c.size(), b0 = busy_r_c.size();
      abort = 1'b1;
      do_start(0);
      do_start(4);
      abort = 1'b0;
      repeat (4) step();
      checks++;
      if (lerr_c.size() - l0 !== 0 || busy_r_c.size() - b0 !== 0) begin
        errors++; $display("FAIL start_abort_same_cycle got len_err %0d busy rises %0d exp 0 0", lerr_c.size() - l0, busy_r_c.size() - b0);
      end
    end
  endtask

  task automatic test_stall();
    int h0 = hs_i.size(), d0 = done_c.size(), l0 = lerr_c.size();
    out_ready = 1'b1;
    do_start(4);
    while (cyc - base < 28) step();
    out_ready = 1'b0;
    while (cyc - base < 30) step();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin start = 1'b1; len = '0; end
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1 || int'(out_idx) !== 2 || rd_en !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got valid %b idx %0d rd_en %b exp 1 2 0", k, out_valid, out_idx, rd_en);
      end
      step();
      start = 1'b0;
    end
    out_ready = 1'b1;
    wait_done(50);
    checks++;
    if (done_c.size() - d0 !== 1 || done_c[done_c.size()-1] - base !== 41) begin
      errors++; $display("FAIL stall_done got count %0d exp one pulse at cycle 41", done_c.size() - d0);
    end
    checks++;
    if (hs_i.size() - h0 !== 4 || hs_i[h0+2] !== 2 || hs_i[h0+3] !== 3) begin
      errors++; $display("FAIL stall_hs got count %0d exp 4 beats idx 0..3", hs_i.size() - h0);
    end
    checks++;
    if (lerr_c.size() - l0 !== 0) begin errors++; $display("FAIL start_while_busy got len_err %0d exp 0", lerr_c.size() - l0); end
  endtask

  task automatic test_abort_reset();
    int r0 = rd_a.size(), a0 = eacc_c.size(), d0 = done_c.size();
    out_ready = 1'b1;
    do_start(4);
    while (cyc - base < 10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge CLK);
    checks++;
    if ({busy, rd_en, EN_max, EN_acc, out_valid, done} !== 6'b0) begin
      errors++; $display("FAIL abort_idle got busy,rd_en,EN_max,EN_acc,out_valid,done=%b exp 000000",
                         {busy, rd_en, EN_max, EN_acc, out_valid, done});
    end
    repeat (10) step();
    checks++;
    if (rd_a.size() - r0 !== 6 || eacc_c.size() - a0 !== 1 || done_c.size() - d0 !== 0) begin
      errors++; $display("FAIL abort_history got reads %0d EN_acc %0d done %0d exp 6 1 0",
                         rd_a.size() - r0, eacc_c.size() - a0, done_c.size() - d0);
    end
    do_start(4);
    while (cyc - base < 20) step();
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || int'(out_idx) !== 0) begin
      errors++; $display("FAIL pre_reset_nout got valid %b idx %0d exp 1 0", out_valid, out_idx);
    end
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, len_err, rd_en, rd_addr, sm_clr, EN_max, EN_acc, out_valid, out_idx} !== '0) begin
      errors++; $display("FAIL midop_reset got %b exp 0",
                         {busy, done, len_err, rd_en, rd_addr, sm_clr, EN_max, EN_acc, out_valid, out_idx});
    end
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;
    repeat (5) step();
    checks++;
    if (done_c.size() - d0 !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_done got done %0d busy %b exp 0 0", done_c.size() - d0, busy);
    end
    d0 = done_c.size();
    do_start(1);
    wait_done(60);
    checks++;
    if (done_c.size() - d0 !== 1 || done_c[done_c.size()-1] - base !== 15 || clr_c[clr_c.size()-1] - base !== 1) begin
      errors++; $display("FAIL restart_after_reset got done count %0d exp one pulse at cycle 15 after clr at 1", done_c.size() - d0);
    end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_len1();
    test_len64();
    test_len_err();
    test_stall();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
